bias_act: RTL and testbench

Post-matmul stage of the neural-net datapath: consumes the H×W row-major FP32 result matrix from `matmul`, adds a per-column bias vector, and applies an optional ReLU. It processes one element at a time through a single shared `add_float` instance, then presents the full output matrix to the next layer with a start/done handshake.

---
 rtl/bias_act_if.sv | 23 ++
 rtl/bias_act.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_bias_act.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bias_act_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bias_act_if : start/done handshake and matrix buses of the bias+activation stage
// Revision    : 1.0
// ----------------------------------------------------------------------------
interface bias_act_if #(
  parameter int S = 32,
  parameter int H = 2,
  parameter int W = 2
);
  logic             start;
  logic [S*H*W-1:0] x;
  logic [S*W-1:0]   bias;
  logic [S*H*W-1:0] o;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             nan;

  modport master (output start, x, bias, input o, busy, done, ovf, nan);
  modport slave  (input start, x, bias, output o, busy, done, ovf, nan);
endinterface
`default_nettype wire

// File: rtl/bias_act.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bias_act : per-column FP32 bias add plus optional ReLU over an HxW matrix,
//            one element at a time through a shared two-cycle add_float.
// Revision : 1.0
// ----------------------------------------------------------------------------

// IEEE-754 single add/sub, round-to-nearest-even; done rises two cycles after
// start and stays high until rst_n is pulled low.
module add_float (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_start,
  input  wire logic        i_op,
  input  wire logic [31:0] i_a,
  input  wire logic [31:0] i_b,
  output logic      [31:0] o_res,
  output logic             o_done,
  output logic             o_ovf,
  output logic             o_nan
);
  logic        w_sa, w_sb, w_eff_sub, w_swap;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [30:0] w_big_mag, w_sml_mag;
  logic        w_big_s;
  logic [7:0]  w_big_e, w_sml_e, w_diff;
  logic [4:0]  w_sh;
  logic [26:0] w_big_m, w_sml_m, w_aligned;
  logic [53:0] w_wide;
  logic [27:0] w_sum;

  logic        r_s1_v, r_s1_sign, r_s1_sub, r_s1_nan, r_s1_inf;
  logic [7:0]  r_s1_exp;
  logic [27:0] r_s1_sum;

  logic [4:0]  w_lz;
  logic [7:0]  w_nsh, w_fexp;
  logic [26:0] w_norm;
  logic [8:0]  w_nexp;
  logic [30:0] w_pack;
  logic        w_up, w_ovf;
  logic [31:0] w_res;

  logic [31:0] r_res;
  logic        r_done, r_ovf, r_nan;

  // Stage 1: order operands by magnitude, align the smaller one, add/sub.
  always_comb begin
    w_sa      = i_a[31];
    w_sb      = i_b[31] ^ i_op;
    w_eff_sub = w_sa ^ w_sb;
    w_a_nan   = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    w_b_nan   = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
    w_a_inf   = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
    w_b_inf   = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
    w_swap    = i_b[30:0] > i_a[30:0];
    w_big_mag = w_swap ? i_b[30:0] : i_a[30:0];
    w_sml_mag = w_swap ? i_a[30:0] : i_b[30:0];
    w_big_s   = w_swap ? w_sb : w_sa;
    w_big_e   = (w_big_mag[30:23] == 8'd0) ? 8'd1 : w_big_mag[30:23];
    w_sml_e   = (w_sml_mag[30:23] == 8'd0) ? 8'd1 : w_sml_mag[30:23];
    w_big_m   = {(w_big_mag[30:23] != 8'd0), w_big_mag[22:0], 3'b000};
    w_sml_m   = {(w_sml_mag[30:23] != 8'd0), w_sml_mag[22:0], 3'b000};
    w_diff    = w_big_e - w_sml_e;
    w_sh      = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
    w_wide    = {w_sml_m, 27'd0} >> w_sh;
    w_aligned = {w_wide[53:28], w_wide[27] | (|w_wide[26:0])};
    w_sum     = w_eff_sub ? ({1'b0, w_big_m} - {1'b0, w_aligned})
                          : ({1'b0, w_big_m} + {1'b0, w_aligned});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_sub  <= 1'b0;
      r_s1_nan  <= 1'b0;
      r_s1_inf  <= 1'b0;
      r_s1_exp  <= 8'd0;
      r_s1_sum  <= 28'd0;
    end else begin
      r_s1_v <= i_start;
      if (i_start) begin
        r_s1_sign <= w_big_s;
        r_s1_sub  <= w_eff_sub;
        r_s1_nan  <= w_a_nan | w_b_nan | (w_a_inf & w_b_inf & w_eff_sub);
        r_s1_inf  <= w_a_inf | w_b_inf;
        r_s1_exp  <= w_big_e;
        r_s1_sum  <= w_sum;
      end
    end
  end

  // Stage 2: normalise (left shift limited so subnormals stay subnormal), round, pack.
  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (r_s1_sum[i]) w_lz = 5'(26 - i);
    end
    w_nsh  = 8'd0;
    w_norm = 27'd0;
    w_nexp = 9'd0;
    if (r_s1_sum[27]) begin
      w_norm = {r_s1_sum[27:2], r_s1_sum[1] | r_s1_sum[0]};
      w_nexp = {1'b0, r_s1_exp} + 9'd1;
    end else begin
      w_nsh  = ({3'b000, w_lz} < r_s1_exp) ? {3'b000, w_lz} : (r_s1_exp - 8'd1);
      w_norm = r_s1_sum[26:0] << w_nsh;
      w_nexp = {1'b0, r_s1_exp - w_nsh};
    end
    w_fexp = w_norm[26] ? w_nexp[7:0] : 8'd0;
    w_up   = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    w_pack = {w_fexp, w_norm[25:3]} + 31'(w_up);
    w_ovf  = 1'b0;
    if (r_s1_nan) begin
      w_res = 32'h7FC00000;
    end else if (r_s1_inf) begin
      w_res = {r_s1_sign, 8'hFF, 23'd0};
    end else if (r_s1_sum == 28'd0) begin
      w_res = {r_s1_sign & ~r_s1_sub, 31'd0};
    end else if ((w_nexp >= 9'd255) || (w_pack[30:23] == 8'hFF)) begin
      w_res = {r_s1_sign, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end else begin
      w_res = {r_s1_sign, w_pack};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res  <= 32'd0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_nan  <= 1'b0;
    end else if (r_s1_v) begin
      r_res  <= w_res;
      r_done <= 1'b1;
      r_ovf  <= w_ovf;
      r_nan  <= r_s1_nan;
    end
  end

  assign o_res  = r_res;
  assign o_done = r_done;
  assign o_ovf  = r_ovf;
  assign o_nan  = r_nan;
endmodule

module bias_act #(
  parameter int S   = 32,
  parameter int H   = 2,
  parameter int W   = 2,
  parameter int ACT = 1
) (
  input wire logic  clk,
  input wire logic  rst,
  bias_act_if.slave bus
);
  localparam int N  = H * W;
  localparam int EW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t         r_state, w_next;
  logic [S*N-1:0] r_x, r_o;
  logic [S*W-1:0] r_bias;
  logic [EW-1:0]  r_e;
  logic [CW-1:0]  r_col;
  logic [S-1:0]   r_sum;
  logic           r_ovf, r_nan;

  logic [S-1:0]   w_a, w_b, w_add_res, w_act;
  logic           w_add_rst_n, w_add_start, w_add_done, w_add_ovf, w_add_nan;
  logic           w_last, w_sum_nan;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < N; k++) begin
      if (r_e == EW'(k)) w_a = r_x[S*(N-1-k) +: S];
    end
    for (int k = 0; k < W; k++) begin
      if (r_col == CW'(k)) w_b = r_bias[S*(W-1-k) +: S];
    end
  end

  assign w_last      = (r_e == EW'(N - 1));
  assign w_add_start = (r_state == ST_ISSUE);
  // STORE doubles as the adder's clear so its sticky done is gone by the next ISSUE.
  assign w_add_rst_n = ~(rst | (r_state == ST_STORE));

  add_float u_add (
    .clk     (clk),
    .rst_n   (w_add_rst_n),
    .i_start (w_add_start),
    .i_op    (1'b0),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_res   (w_add_res),
    .o_done  (w_add_done),
    .o_ovf   (w_add_ovf),
    .o_nan   (w_add_nan)
  );

  // ReLU: negative non-NaN values (including -0.0) become +0.0.
  always_comb begin
    w_sum_nan = (r_sum[30:23] == 8'hFF) && (r_sum[22:0] != 23'd0);
    w_act     = r_sum;
    if ((ACT == 1) && r_sum[S-1] && !w_sum_nan) w_act = '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_add_done) w_next = ST_STORE;
      ST_STORE: w_next = w_last ? ST_FIN : ST_ISSUE;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_bias  <= '0;
      r_o     <= '0;
      r_e     <= '0;
      r_col   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_nan   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_x    <= bus.x;
            r_bias <= bus.bias;
            r_e    <= '0;
            r_col  <= '0;
            r_ovf  <= 1'b0;
            r_nan  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_add_done) begin
            r_sum <= w_add_res;
            r_ovf <= r_ovf | w_add_ovf;
            r_nan <= r_nan | w_add_nan;
          end
        end
        ST_STORE: begin
          for (int k = 0; k < N; k++) begin
            if (r_e == EW'(k)) r_o[S*(N-1-k) +: S] <= w_act;
          end
          if (!w_last) begin
            r_e   <= r_e + EW'(1);
            r_col <= (r_col == CW'(W - 1)) ? '0 : r_col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o    = r_o;
  assign bus.busy = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_STORE);
  assign bus.done = (r_state == ST_FIN);
  assign bus.ovf  = r_ovf;
  assign bus.nan  = r_nan;
endmodule
`default_nettype wire

// File: tb/tb_bias_act.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bias_act : scoreboard bench driving a ReLU and an identity bias_act in lockstep
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_bias_act;
  localparam int L   = 2;
  localparam int NEL = 4;

  localparam logic [127:0] X1 = 128'h3F800000_40000000_40400000_40800000;
  localparam logic [63:0]  B1 = 64'h3F000000_3F800000;
  localparam logic [127:0] O1 = 128'h3FC00000_40400000_40600000_40A00000;
  localparam logic [127:0] X2 = 128'hC0000000_7FC00000_3F800000_40000000;
  localparam logic [63:0]  B2 = 64'h3F000000_3F800000;
  localparam logic [127:0] O2R = 128'h00000000_7FC00000_3FC00000_40400000;
  localparam logic [127:0] O2I = 128'hBFC00000_7FC00000_3FC00000_40400000;
  localparam logic [127:0] X3 = 128'h3F800000_40000000_40400000_7F7FFFFF;
  localparam logic [63:0]  B3 = 64'h3F000000_7F7FFFFF;
  localparam logic [127:0] O3 = 128'h3FC00000_7F7FFFFF_40600000_7F800000;
  localparam logic [127:0] X4 = 128'h80000000_40400000_BF800000_40800000;
  localparam logic [63:0]  B4 = 64'h80000000_C0000000;
  localparam logic [127:0] O4R = 128'h00000000_3F800000_00000000_40000000;
  localparam logic [127:0] O4I = 128'h80000000_3F800000_BF800000_40000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bias_act_if #(.S(32), .H(2), .W(2)) bus1 ();
  bias_act_if #(.S(32), .H(2), .W(2)) bus0 ();

  bias_act #(.S(32), .H(2), .W(2), .ACT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  bias_act #(.S(32), .H(2), .W(2), .ACT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    logic [127:0] o;
    logic         ovf;
    logic         nan;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  int n_done1 = 0;
  int n_done0 = 0;
  int mark;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [127:0] o, input logic ovf,
                           input logic nan, input exp_t e);
    for (int i = 0; i < NEL; i++)
      cmp($sformatf("%s o[%0d]", tag, i), o[127-32*i -: 32], e.o[127-32*i -: 32]);
    cmp({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
    cmp({tag, " nan"}, 32'(nan), 32'(e.nan));
    // start-sampling edge to done: H*W*(L+2) edges, i.e. done in cycle k+1+H*W*(L+2)
    cmp({tag, " latency"}, 32'(cyc - t0), 32'(NEL * (L + 2)));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus1.done) begin
      n_done1++;
      if (q1.size() == 0) cmp("spurious done relu", 32'(q1.size()), 32'd1);
      else begin
        e = q1.pop_front();
        check_out("relu", bus1.o, bus1.ovf, bus1.nan, e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus0.done) begin
      n_done0++;
      if (q0.size() == 0) cmp("spurious done ident", 32'(q0.size()), 32'd1);
      else begin
        e = q0.pop_front();
        check_out("ident", bus0.o, bus0.ovf, bus0.nan, e);
      end
    end
  end

  task automatic pulse_start(input logic [127:0] vx, input logic [63:0] vb);
    @(posedge clk); #1;
    bus1.x = vx; bus0.x = vx; bus1.bias = vb; bus0.bias = vb;
    bus1.start = 1'b1; bus0.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0; bus0.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic start_pass(input logic [127:0] vx, input logic [63:0] vb,
                            input logic [127:0] e_relu, input logic [127:0] e_ident,
                            input logic eo, input logic en);
    q1.push_back('{o: e_relu, ovf: eo, nan: en});
    q0.push_back('{o: e_ident, ovf: eo, nan: en});
    pulse_start(vx, vb);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    cmp({tag, " drain"}, 32'(q1.size() + q0.size()), 32'd0);
  endtask

  initial begin
    bus1.start = 1'b0; bus0.start = 1'b0;
    bus1.x = '0; bus0.x = '0; bus1.bias = '0; bus0.bias = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset o hi", bus1.o[127:96], 32'd0);
    cmp("reset o lo", bus1.o[31:0], 32'd0);
    cmp("reset busy", 32'(bus1.busy), 32'd0);
    cmp("reset done", 32'(bus1.done), 32'd0);
    cmp("reset ovf", 32'(bus1.ovf), 32'd0);
    cmp("reset nan", 32'(bus1.nan), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    start_pass(X1, B1, O1, O1, 1'b0, 1'b0);
    cmp("busy after start", 32'(bus1.busy), 32'd1);
    wait_drain("p1");

    start_pass(X2, B2, O2R, O2I, 1'b0, 1'b1);
    wait_drain("p2");
    repeat (2) @(negedge clk);
    cmp("nan held", 32'(bus1.nan), 32'd1);

    start_pass(X3, B3, O3, O3, 1'b1, 1'b0);
    wait_drain("p3");
    repeat (3) @(negedge clk);
    cmp("ovf held relu", 32'(bus1.ovf), 32'd1);
    cmp("ovf held ident", 32'(bus0.ovf), 32'd1);
    start_pass(X1, B1, O1, O1, 1'b0, 1'b0);
    cmp("ovf cleared by start", 32'(bus1.ovf), 32'd0);
    wait_drain("p1b");

    // second start mid-pass with different data must be ignored
    mark = n_done1;
    start_pass(X4, B4, O4R, O4I, 1'b0, 1'b0);
    repeat (6) @(posedge clk); #1;
    bus1.x = X1; bus0.x = X1; bus1.bias = B1; bus0.bias = B1;
    bus1.start = 1'b1; bus0.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0; bus0.start = 1'b0;
    wait_drain("p4");
    repeat (20) @(posedge clk);
    cmp("single done", 32'(n_done1 - mark), 32'd1);

    // abort in the first WAIT cycle of element 2
    mark = n_done1;
    pulse_start(X2, B2);
    repeat (9) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp("abort o hi", bus1.o[127:96], 32'd0);
    cmp("abort o mid", bus1.o[95:64], 32'd0);
    cmp("abort busy", 32'(bus1.busy), 32'd0);
    cmp("abort done", 32'(bus1.done), 32'd0);
    cmp("abort nan", 32'(bus1.nan), 32'd0);
    repeat (20) @(posedge clk);
    cmp("no done after abort", 32'(n_done1 - mark), 32'd0);
    start_pass(X3, B3, O3, O3, 1'b1, 1'b0);
    wait_drain("p5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
